// File: rtl/mem_sync_tracker.sv
// ---------------------------------------------------------------------------
// mem_sync_tracker
//
// Per-bank row-cache tracker. Maps a full DRAM row address onto one of
// 2^CHWIDTH fully associative cached-row slots, with hit detection, dirty
// tracking, round-robin victim replacement and a writeback/fill handshake
// closed by a single-cycle sync strobe.
//
// Optional feature: define MEMSYNC_STATS_EN to add saturating hit/miss/
// writeback statistics counters (hit_cnt, miss_cnt, wb_cnt).
// ---------------------------------------------------------------------------
module mem_sync_tracker #(
    parameter int          CHWIDTH   = 6,
    parameter int          ADDRWIDTH = 17,
    parameter logic [4:0]  RDSTATE   = 5'b01011,
    parameter logic [4:0]  WRSTATE   = 5'b10010
`ifdef MEMSYNC_STATS_EN
    ,
    parameter int          CNTWIDTH  = 32
`endif
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [4:0]           BankFSM,
    input  logic [ADDRWIDTH-1:0] RowId,
    input  logic                 sync,
    output logic [CHWIDTH-1:0]   cRowId,
    output logic                 stall,
    output logic                 hit,
    output logic                 evict_valid,
    output logic [ADDRWIDTH-1:0] evict_row,
    output logic                 fill_valid
`ifdef MEMSYNC_STATS_EN
    ,
    output logic [CNTWIDTH-1:0]  hit_cnt,
    output logic [CNTWIDTH-1:0]  miss_cnt,
    output logic [CNTWIDTH-1:0]  wb_cnt
`endif
);

    localparam int CHROWS = 1 << CHWIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WRITEBACK,
        S_ALLOCATE,
        S_ACTIVE
    } state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t                 state, state_d;
    logic [ADDRWIDTH-1:0]   row_q, row_d;         // latched request row
    logic [CHWIDTH-1:0]     rr_ptr, rr_ptr_d;     // round-robin victim pointer
    logic [CHROWS-1:0]      valid;
    logic [CHROWS-1:0]      dirty;
    logic [ADDRWIDTH-1:0]   tag [CHROWS];

    // Registered-output next values
    logic [CHWIDTH-1:0]     slot_d;
    logic                   stall_d;
    logic                   hit_d;
    logic                   evict_valid_d;
    logic [ADDRWIDTH-1:0]   evict_row_d;
    logic                   fill_valid_d;

    // Slot-array update strobes (all act on the slot held in cRowId)
    logic                   install;     // write tag, set valid, clear dirty
    logic                   clr_dirty;   // victim written back
    logic                   set_dirty;   // write access seen in ACTIVE

    // Statistics event strobes
    logic                   hit_evt;
    logic                   miss_evt;
    logic                   wb_evt;

    // Lookup results
    logic                   match_found;
    logic [CHWIDTH-1:0]     match_idx;
    logic                   free_found;
    logic [CHWIDTH-1:0]     free_idx;

    logic                   is_access;
    assign is_access = (BankFSM == RDSTATE) || (BankFSM == WRSTATE);

    // -----------------------------------------------------------------------
    // Associative compare of the latched row against every valid tag, plus
    // lowest-index free slot search. Scanning downward lets the lowest index
    // overwrite any higher one.
    // -----------------------------------------------------------------------
    always_comb begin
        match_found = 1'b0;
        match_idx   = '0;
        free_found  = 1'b0;
        free_idx    = '0;
        for (int i = CHROWS - 1; i >= 0; i--) begin
            if (valid[i] && (tag[i] == row_q)) begin
                match_found = 1'b1;
                match_idx   = i[CHWIDTH-1:0];
            end
            if (!valid[i]) begin
                free_found = 1'b1;
                free_idx   = i[CHWIDTH-1:0];
            end
        end
    end

    // -----------------------------------------------------------------------
    // State register and registered outputs
    // -----------------------------------------------------------------------
    // NOTE: sequential state is assigned with <= only so every flop samples
    // pre-edge values; blocking assignments here would create ordering races.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            row_q       <= '0;
            rr_ptr      <= '0;
            cRowId      <= '0;
            stall       <= 1'b0;
            hit         <= 1'b0;
            evict_valid <= 1'b0;
            evict_row   <= '0;
            fill_valid  <= 1'b0;
        end else begin
            state       <= state_d;
            row_q       <= row_d;
            rr_ptr      <= rr_ptr_d;
            cRowId      <= slot_d;
            stall       <= stall_d;
            hit         <= hit_d;
            evict_valid <= evict_valid_d;
            evict_row   <= evict_row_d;
            fill_valid  <= fill_valid_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and next-output logic
    // -----------------------------------------------------------------------
    // NOTE: every signal gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d       = state;
        row_d         = row_q;
        rr_ptr_d      = rr_ptr;
        slot_d        = cRowId;
        stall_d       = stall;
        hit_d         = hit;
        evict_valid_d = evict_valid;
        evict_row_d   = evict_row;
        fill_valid_d  = fill_valid;
        install       = 1'b0;
        clr_dirty     = 1'b0;
        set_dirty     = 1'b0;
        hit_evt       = 1'b0;
        miss_evt      = 1'b0;
        wb_evt        = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (is_access) begin
                    row_d   = RowId;
                    stall_d = 1'b1;
                    state_d = S_LOOKUP;
                end
            end

            S_LOOKUP: begin
                if (match_found) begin
                    hit_evt = 1'b1;
                    slot_d  = match_idx;
                    hit_d   = 1'b1;
                    stall_d = 1'b0;
                    state_d = S_ACTIVE;
                end else begin
                    miss_evt = 1'b1;
                    if (free_found) begin
                        slot_d       = free_idx;
                        fill_valid_d = 1'b1;
                        state_d      = S_ALLOCATE;
                    end else begin
                        // All slots busy: replace the round-robin victim.
                        slot_d   = rr_ptr;
                        rr_ptr_d = rr_ptr + 1'b1;
                        if (dirty[rr_ptr]) begin
                            evict_valid_d = 1'b1;
                            evict_row_d   = tag[rr_ptr];
                            state_d       = S_WRITEBACK;
                        end else begin
                            fill_valid_d = 1'b1;
                            state_d      = S_ALLOCATE;
                        end
                    end
                end
            end

            S_WRITEBACK: begin
                if (sync) begin
                    wb_evt        = 1'b1;
                    clr_dirty     = 1'b1;
                    evict_valid_d = 1'b0;
                    fill_valid_d  = 1'b1;
                    state_d       = S_ALLOCATE;
                end
            end

            S_ALLOCATE: begin
                if (sync) begin
                    install      = 1'b1;
                    fill_valid_d = 1'b0;
                    stall_d      = 1'b0;
                    hit_d        = 1'b0;
                    state_d      = S_ACTIVE;
                end
            end

            S_ACTIVE: begin
                if (BankFSM == WRSTATE) begin
                    set_dirty = 1'b1;
                end else if (!is_access) begin
                    hit_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Valid and dirty bits per slot
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= '0;
            dirty <= '0;
        end else begin
            if (install) begin
                valid[cRowId] <= 1'b1;
                dirty[cRowId] <= 1'b0;
            end else if (clr_dirty) begin
                dirty[cRowId] <= 1'b0;
            end else if (set_dirty) begin
                dirty[cRowId] <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Tag storage
    // -----------------------------------------------------------------------
    // NOTE: the tag array is deliberately not reset; a tag is only ever read
    // behind its valid bit, so clearing valid on reset is sufficient.
    always_ff @(posedge clk) begin
        if (install) begin
            tag[cRowId] <= row_q;
        end
    end

`ifdef MEMSYNC_STATS_EN
    // -----------------------------------------------------------------------
    // Saturating statistics counters
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
            wb_cnt   <= '0;
        end else begin
            if (hit_evt && (hit_cnt != '1)) begin
                hit_cnt <= hit_cnt + 1'b1;
            end
            if (miss_evt && (miss_cnt != '1)) begin
                miss_cnt <= miss_cnt + 1'b1;
            end
            if (wb_evt && (wb_cnt != '1)) begin
                wb_cnt <= wb_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: doc/mem_sync_tracker.md
Name: mem_sync_tracker

Overview:
Per-bank row-cache tracker and successor to the fixed per-bank MEMSync engine. It maps a full DRAM row address onto one of 2^CHWIDTH cached-row slots, fully associative. It adds hit detection, dirty tracking, round-robin victim replacement and a writeback handshake. One instance sits per bank under the memory sync top level, between the bank FSM and the row-buffer storage.

Parameters:
CHWIDTH, 6, log2 of cached-row slots per bank (CHROWS = 2^CHWIDTH)
ADDRWIDTH, 17, row address width
RDSTATE, 5'b01011, bank FSM encoding that means a read access
WRSTATE, 5'b10010, bank FSM encoding that means a write access
CNTWIDTH, 32, statistics counter width (only with the optional feature)

Ports:
clk  in  1  clock; all state updates on the rising edge
reset_n  in  1  asynchronous, active-low reset
BankFSM  in  5  bank state; 0 = idle, RDSTATE/WRSTATE = access, other codes treated as idle
RowId  in  ADDRWIDTH  row address; sampled only on the access-start cycle
sync  in  1  single-cycle completion strobe for the pending fill or writeback
cRowId  out  CHWIDTH  slot index serving the current access
stall  out  1  bank must hold; the access is not yet servable
hit  out  1  the current access hit an existing slot
evict_valid  out  1  writeback of a dirty victim requested
evict_row  out  ADDRWIDTH  row address of the victim being written back
fill_valid  out  1  fill of the new row into cRowId requested

Behaviour:
- Reset, async, with reset_n low: state IDLE; all valid and dirty bits 0; round-robin pointer 0; all outputs 0. Reset mid-transaction abandons it with no writeback. Outputs are registered.
- Access start: in IDLE, BankFSM equal to RDSTATE or WRSTATE latches RowId and access type and moves to LOOKUP. stall rises the next cycle.
- LOOKUP, 1 cycle, stall=1: compare the latched row against all valid tags.
  - Hit: cRowId = matching slot, hit=1, go to ACTIVE.
  - Miss with an invalid slot: take the lowest-index invalid slot and go to ALLOCATE.
  - Miss with all slots valid: victim = round-robin pointer, then advance the pointer modulo CHROWS (wraps 2^CHWIDTH-1 -> 0). A dirty victim goes to WRITEBACK; a clean victim goes to ALLOCATE.
- WRITEBACK: stall=1, evict_valid=1, evict_row = victim tag. sync clears dirty, deasserts evict_valid next cycle and moves to ALLOCATE.
- ALLOCATE: stall=1, fill_valid=1, cRowId = slot. sync writes the tag, sets valid, clears dirty, and moves to ACTIVE with hit=0.
- ACTIVE: stall=0. A WRSTATE access sets that slot's dirty bit in the cycle it is seen. BankFSM returning to a non-access code goes to IDLE and clears hit. cRowId holds its value.
- sync outside WRITEBACK/ALLOCATE is ignored.
- BankFSM changes during LOOKUP, WRITEBACK or ALLOCATE are ignored; the latched request completes.
- A new access needs one IDLE cycle in between. Back-to-back access codes keep the engine in ACTIVE on the same slot.
- Latency:
  - hit: stall high exactly 1 cycle
  - clean miss: 1 + cycles to sync + 1
  - dirty miss: adds the writeback wait

Optional Feature:
MEMSYNC_STATS_EN. When defined, adds outputs hit_cnt, miss_cnt and wb_cnt, each CNTWIDTH wide, reset to 0.
- hit_cnt increments on a LOOKUP hit.
- miss_cnt increments on a LOOKUP miss.
- wb_cnt increments on a WRITEBACK sync.
- All three saturate at all-ones.
When not defined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset mid-ALLOCATE. CHWIDTH=2; write row 0x0AB1, hold sync low; pull reset_n low for 1 ns -> all outputs 0 immediately; re-access 0x0AB1 -> miss, slot 0.
- Cold miss then hit. Read 0x1234 -> stall=1, fill_valid=1, cRowId=0; pulse sync -> stall=0, hit=0. Idle, then read 0x1234 -> stall for 1 cycle, hit=1, cRowId=0.
- Fill to capacity. CHWIDTH=2; read rows 1,2,3,4 with sync each -> cRowId 0,1,2,3. Read row 5 -> clean victim slot 0, no evict_valid, fill cRowId=0.
- Dirty writeback. Write row 1 into slot 0, then fill rows 2-4 (CHWIDTH=2). Read row 9 -> evict_valid=1, evict_row=1. sync -> fill_valid=1, cRowId=0. sync -> ACTIVE.
- Pointer wrap and stray sync. Cause 5 evictions with CHWIDTH=2 -> victims 0,1,2,3,0. A sync pulse in IDLE/ACTIVE changes no state.
- MEMSYNC_STATS_EN. Run the scenario 2 sequence -> hit_cnt=1, miss_cnt=1, wb_cnt=0.
